acc_exec_ctrl: RTL and testbench

- Execute-stage controller for the 8-bit accumulator core.
- Accepts one decoded instruction at a time over a valid/ready handshake and fetches a memory operand when the instruction needs one.
- Drives the combinational ALU's unit/op selects and operands, owns the accumulator register, and reports retire, branch and error events to the fetch stage.

---
 rtl/acc_exec_ctrl.sv | 168 ++++++++++++++++
 tb/tb_acc_exec_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_exec_ctrl.sv
// Execute-stage controller for the 8-bit accumulator core.
// Accepts one decoded instruction per handshake, optionally fetches a memory
// operand, drives the external ALU, and owns the accumulator register.
module acc_exec_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_in,
  input  logic [12:0] instr_in,
  output logic        instr_ready_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [7:0]  mem_addr_out,
  output logic [7:0]  mem_wdata_out,
  input  logic [7:0]  mem_rdata_in,
  input  logic        mem_ack_in,
  output logic [2:0]  alu_unit_sel_out,
  output logic        alu_op_sel_out,
  output logic [7:0]  alu_acc_out,
  output logic [7:0]  alu_src_out,
  input  logic [7:0]  alu_res_in,
  output logic [7:0]  acc_out,
  output logic        done_out,
  output logic        branch_valid_out,
  output logic [7:0]  branch_target_out,
  output logic        err_out
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEM, EXEC} state_t;

  state_t      state, state_d;
  logic [12:0] instr_q;
  logic [7:0]  src_q, acc_q, cnt_q, target_q;
  logic        done_q, branch_q, err_q;

  logic [3:0]  in_op, q_op;
  logic [7:0]  cnt_inc;
  logic        fire, in_illegal, in_mem, is_st, timeout;

  // Decode of the offered and the held instruction
  always_comb begin
    in_op      = instr_in[11:8];
    q_op       = instr_q[11:8];
    fire       = instr_valid_in && (state == IDLE);
    in_illegal = (in_op > 4'hC);
    in_mem     = (in_op == 4'hB) || ((in_op <= 4'h9) && instr_in[12]);
    is_st      = (q_op == 4'hB);
    cnt_inc    = cnt_q + 8'd1;
    timeout    = (cnt_inc == TMO);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; ack takes priority over the timeout
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (fire) begin
          if (in_illegal)  state_d = IDLE;
          else if (in_mem) state_d = MEM;
          else             state_d = EXEC;
        end
      end
      MEM: begin
        if (mem_ack_in)   state_d = is_st ? IDLE : EXEC;
        else if (timeout) state_d = IDLE;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q  <= '0;
      src_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
      branch_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      branch_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            instr_q <= instr_in;
            cnt_q   <= '0;
            if (in_illegal)  err_q <= 1'b1;
            else if (!in_mem) src_q <= instr_in[7:0];
          end
        end
        MEM: begin
          cnt_q <= cnt_inc;
          if (mem_ack_in) begin
            if (is_st) done_q <= 1'b1;
            else       src_q  <= mem_rdata_in;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        EXEC: begin
          if (q_op <= 4'h9) acc_q <= alu_res_in;
          done_q <= 1'b1;
          if ((q_op == 4'hA) && (acc_q != 8'h00)) begin
            branch_q <= 1'b1;
            target_q <= instr_q[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Memory interface, held stable for the whole MEM visit
  always_comb begin
    instr_ready_out = (state == IDLE) && rst_n;
    mem_req_out     = (state == MEM);
    mem_we_out      = (state == MEM) && is_st;
    mem_addr_out    = (state == MEM) ? instr_q[7:0] : '0;
    mem_wdata_out   = ((state == MEM) && is_st) ? acc_q : '0;
  end

  // ALU selects from the opcode during EXEC, idle selects otherwise
  always_comb begin
    alu_unit_sel_out = 3'b111;
    alu_op_sel_out   = 1'b0;
    alu_src_out      = '0;
    alu_acc_out      = acc_q;
    if (state == EXEC) begin
      alu_src_out = src_q;
      case (q_op)
        4'h0: begin alu_unit_sel_out = 3'b000; alu_op_sel_out = 1'b0; end
        4'h1: begin alu_unit_sel_out = 3'b000; alu_op_sel_out = 1'b1; end
        4'h2: begin alu_unit_sel_out = 3'b001; alu_op_sel_out = 1'b0; end
        4'h3: begin alu_unit_sel_out = 3'b001; alu_op_sel_out = 1'b1; end
        4'h4: begin alu_unit_sel_out = 3'b010; alu_op_sel_out = 1'b0; end
        4'h5: begin alu_unit_sel_out = 3'b010; alu_op_sel_out = 1'b1; end
        4'h6: begin alu_unit_sel_out = 3'b011; alu_op_sel_out = 1'b0; end
        4'h7: begin alu_unit_sel_out = 3'b100; alu_op_sel_out = 1'b0; end
        4'h8: begin alu_unit_sel_out = 3'b101; alu_op_sel_out = 1'b0; end
        4'h9: begin alu_unit_sel_out = 3'b110; alu_op_sel_out = 1'b0; end
        default: begin alu_unit_sel_out = 3'b111; alu_op_sel_out = 1'b0; end
      endcase
    end
  end

  always_comb begin
    acc_out           = acc_q;
    done_out          = done_q;
    branch_valid_out  = branch_q;
    branch_target_out = target_q;
    err_out           = err_q;
  end

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Directed bench for acc_exec_ctrl with a behavioural ALU on the side.
module tb_acc_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_in;
  logic [12:0] instr_in;
  logic        instr_ready_out;
  logic        mem_req_out, mem_we_out;
  logic [7:0]  mem_addr_out, mem_wdata_out, mem_rdata_in;
  logic        mem_ack_in;
  logic [2:0]  alu_unit_sel_out;
  logic        alu_op_sel_out;
  logic [7:0]  alu_acc_out, alu_src_out, alu_res_in;
  logic [7:0]  acc_out;
  logic        done_out, branch_valid_out, err_out;
  logic [7:0]  branch_target_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  acc_exec_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_in(instr_valid_in), .instr_in(instr_in),
    .instr_ready_out(instr_ready_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in),
    .alu_unit_sel_out(alu_unit_sel_out), .alu_op_sel_out(alu_op_sel_out),
    .alu_acc_out(alu_acc_out), .alu_src_out(alu_src_out),
    .alu_res_in(alu_res_in), .acc_out(acc_out), .done_out(done_out),
    .branch_valid_out(branch_valid_out),
    .branch_target_out(branch_target_out), .err_out(err_out)
  );

  // External combinational ALU
  logic [15:0] prod;
  always_comb begin
    prod = 16'(alu_acc_out) * 16'(alu_src_out);
    case (alu_unit_sel_out)
      3'b000:  alu_res_in = alu_op_sel_out ? alu_acc_out - alu_src_out : alu_acc_out + alu_src_out;
      3'b001:  alu_res_in = alu_op_sel_out ? ~(alu_acc_out & alu_src_out) : (alu_acc_out & alu_src_out);
      3'b010:  alu_res_in = alu_op_sel_out ? (alu_acc_out >> alu_src_out[2:0]) : (alu_acc_out << alu_src_out[2:0]);
      3'b011:  alu_res_in = alu_src_out;
      3'b100:  alu_res_in = alu_acc_out | alu_src_out;
      3'b101:  alu_res_in = alu_acc_out ^ alu_src_out;
      3'b110:  alu_res_in = prod[7:0];
      default: alu_res_in = alu_acc_out;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake edge, then EXEC-cycle checks, then retire-cycle checks
  task automatic imm(input logic [3:0] op, input logic [7:0] val, input logic [2:0] unit,
                     input logic opsel, input logic [7:0] exp_acc);
    instr_valid_in = 1'b1;
    instr_in = {1'b0, op, val};
    tick();
    instr_valid_in = 1'b0;
    check("exec_ready", 16'(instr_ready_out), 16'h0);
    check("exec_unit", 16'(alu_unit_sel_out), 16'(unit));
    check("exec_opsel", 16'(alu_op_sel_out), 16'(opsel));
    check("exec_src", 16'(alu_src_out), 16'(val));
    check("exec_nodone", 16'(done_out), 16'h0);
    tick();
    check("ret_done", 16'(done_out), 16'h1);
    check("ret_acc", 16'(acc_out), 16'(exp_acc));
    check("ret_ready", 16'(instr_ready_out), 16'h1);
  endtask

  task automatic issue(input logic [12:0] ins);
    instr_valid_in = 1'b1;
    instr_in = ins;
    tick();
    instr_valid_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid_in = 1'b0; instr_in = '0;
    mem_rdata_in = '0; mem_ack_in = 1'b0;
    #1;
    tick(); tick(); tick();
    check("rst_ready", 16'(instr_ready_out), 16'h0);
    check("rst_acc", 16'(acc_out), 16'h0);
    check("rst_req", 16'(mem_req_out), 16'h0);
    check("rst_done", 16'(done_out), 16'h0);
    check("rst_err", 16'(err_out), 16'h0);
    check("rst_unit", 16'(alu_unit_sel_out), 16'h7);
    check("rst_target", 16'(branch_target_out), 16'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 16'(instr_ready_out), 16'h1);

    imm(4'h6, 8'h5A, 3'b011, 1'b0, 8'h5A);
    imm(4'h0, 8'h03, 3'b000, 1'b0, 8'h5D);
    imm(4'h1, 8'h10, 3'b000, 1'b1, 8'h4D);

    imm(4'h6, 8'h81, 3'b011, 1'b0, 8'h81);
    imm(4'h5, 8'h01, 3'b010, 1'b1, 8'h40);
    imm(4'h4, 8'h03, 3'b010, 1'b0, 8'h00);
    imm(4'h6, 8'h81, 3'b011, 1'b0, 8'h81);
    imm(4'h4, 8'h03, 3'b010, 1'b0, 8'h08);
    imm(4'h6, 8'h81, 3'b011, 1'b0, 8'h81);
    imm(4'h3, 8'hF0, 3'b001, 1'b1, 8'h7F);
    imm(4'h9, 8'h03, 3'b110, 1'b0, 8'h7D);

    // Memory ADD from 0x20, ack in the third MEM cycle
    issue({1'b1, 4'h0, 8'h20});
    for (int unsigned i = 0; i < 3; i++) begin
      check("madd_req", 16'(mem_req_out), 16'h1);
      check("madd_addr", 16'(mem_addr_out), 16'h20);
      check("madd_we", 16'(mem_we_out), 16'h0);
      check("madd_nodone", 16'(done_out), 16'h0);
      if (i == 2) begin mem_ack_in = 1'b1; mem_rdata_in = 8'h11; end
      tick();
    end
    mem_ack_in = 1'b0; mem_rdata_in = 8'h00;
    check("madd_exec_req", 16'(mem_req_out), 16'h0);
    check("madd_exec_src", 16'(alu_src_out), 16'h11);
    tick();
    check("madd_done", 16'(done_out), 16'h1);
    check("madd_acc", 16'(acc_out), 16'h8E);

    // Store to 0x21, immediate ack
    issue({1'b0, 4'hB, 8'h21});
    check("st_req", 16'(mem_req_out), 16'h1);
    check("st_we", 16'(mem_we_out), 16'h1);
    check("st_addr", 16'(mem_addr_out), 16'h21);
    check("st_wdata", 16'(mem_wdata_out), 16'h8E);
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    check("st_done", 16'(done_out), 16'h1);
    check("st_acc", 16'(acc_out), 16'h8E);
    check("st_req_off", 16'(mem_req_out), 16'h0);
    check("st_ready", 16'(instr_ready_out), 16'h1);

    // Stray ack while idle has no effect
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    check("stray_ack_done", 16'(done_out), 16'h0);
    check("stray_ack_req", 16'(mem_req_out), 16'h0);

    // Timeout: no ack for 4 cycles
    issue({1'b1, 4'h0, 8'h30});
    for (int unsigned i = 0; i < 4; i++) begin
      check("tmo_req", 16'(mem_req_out), 16'h1);
      check("tmo_noerr", 16'(err_out), 16'h0);
      tick();
    end
    check("tmo_req_off", 16'(mem_req_out), 16'h0);
    check("tmo_err", 16'(err_out), 16'h1);
    check("tmo_nodone", 16'(done_out), 16'h0);
    check("tmo_acc", 16'(acc_out), 16'h8E);
    check("tmo_ready", 16'(instr_ready_out), 16'h1);
    tick();
    check("tmo_err_pulse", 16'(err_out), 16'h0);

    // Ack on the timeout cycle wins: XOR with 0xFF
    issue({1'b1, 4'h8, 8'h31});
    for (int unsigned i = 0; i < 4; i++) begin
      check("late_req", 16'(mem_req_out), 16'h1);
      if (i == 3) begin mem_ack_in = 1'b1; mem_rdata_in = 8'hFF; end
      tick();
    end
    mem_ack_in = 1'b0;
    check("late_noerr", 16'(err_out), 16'h0);
    check("late_exec_unit", 16'(alu_unit_sel_out), 16'h5);
    tick();
    check("late_done", 16'(done_out), 16'h1);
    check("late_acc", 16'(acc_out), 16'h71);
    check("late_noerr2", 16'(err_out), 16'h0);

    // BNEZ with acc == 0, then acc == 1
    imm(4'h6, 8'h00, 3'b011, 1'b0, 8'h00);
    issue({1'b1, 4'hA, 8'h37});
    check("bz_exec_unit", 16'(alu_unit_sel_out), 16'h7);
    tick();
    check("bz_done", 16'(done_out), 16'h1);
    check("bz_nobranch", 16'(branch_valid_out), 16'h0);
    check("bz_acc", 16'(acc_out), 16'h0);
    imm(4'h6, 8'h01, 3'b011, 1'b0, 8'h01);
    issue({1'b0, 4'hA, 8'h37});
    tick();
    check("bnz_done", 16'(done_out), 16'h1);
    check("bnz_branch", 16'(branch_valid_out), 16'h1);
    check("bnz_target", 16'(branch_target_out), 16'h37);
    check("bnz_acc", 16'(acc_out), 16'h01);
    tick();
    check("bnz_pulse", 16'(branch_valid_out), 16'h0);
    check("bnz_done_pulse", 16'(done_out), 16'h0);

    // NOP keeps acc
    issue({1'b1, 4'hC, 8'h99});
    tick();
    check("nop_done", 16'(done_out), 16'h1);
    check("nop_acc", 16'(acc_out), 16'h01);

    // Illegal opcode
    issue({1'b0, 4'hE, 8'h00});
    check("ill_err", 16'(err_out), 16'h1);
    check("ill_ready", 16'(instr_ready_out), 16'h1);
    check("ill_nodone", 16'(done_out), 16'h0);
    check("ill_acc", 16'(acc_out), 16'h01);
    tick();
    check("ill_err_pulse", 16'(err_out), 16'h0);

    // Reset during MEM with valid held high throughout
    issue({1'b1, 4'h6, 8'h40});
    check("rmem_req", 16'(mem_req_out), 16'h1);
    rst_n = 1'b0;
    instr_valid_in = 1'b1;
    instr_in = {1'b0, 4'h6, 8'h5A};
    tick();
    check("rmem_req_off", 16'(mem_req_out), 16'h0);
    check("rmem_acc", 16'(acc_out), 16'h0);
    check("rmem_nodone", 16'(done_out), 16'h0);
    check("rmem_noerr", 16'(err_out), 16'h0);
    check("rmem_ready", 16'(instr_ready_out), 16'h0);
    tick();
    check("rmem_hold_unit", 16'(alu_unit_sel_out), 16'h7);
    check("rmem_hold_done", 16'(done_out), 16'h0);
    rst_n = 1'b1;
    tick();
    instr_valid_in = 1'b0;
    check("rrel_exec_unit", 16'(alu_unit_sel_out), 16'h3);
    check("rrel_ready", 16'(instr_ready_out), 16'h0);
    tick();
    check("rrel_done", 16'(done_out), 16'h1);
    check("rrel_acc", 16'(acc_out), 16'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
